// File: rtl/signo_pkg.sv
// ============================================================================
// Module : signo_pkg
// Brief  : Shared state encoding and +/-1 decode helpers for signo_hyst.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package signo_pkg;

  typedef enum logic {
    ST_POS = 1'b0,
    ST_NEG = 1'b1
  } state_t;

  localparam int DW_MAX   = 32;
  localparam int WORD_MAX = 64;

  // +1 or -1 in the low r bits; the upper bits are left at zero.
  function automatic logic [WORD_MAX-1:0] sgn_word(input int r, input state_t st);
    logic [WORD_MAX-1:0] w;
    if (st == ST_POS) w = {{(WORD_MAX-1){1'b0}}, 1'b1};
    else              w = ({{(WORD_MAX-1){1'b0}}, 1'b1} << r) - {{(WORD_MAX-1){1'b0}}, 1'b1};
    return w;
  endfunction

  function automatic logic [1:0] sgn_2b(input state_t st);
    return (st == ST_POS) ? 2'b01 : 2'b11;
  endfunction

endpackage

`default_nettype wire

// File: rtl/signo_dwell_cnt.sv
// ============================================================================
// Module : signo_dwell_cnt
// Brief  : Saturating consecutive-event counter; fires when the run reaches
//          max(threshold,1) and clears itself on fire or on a missing event.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module signo_dwell_cnt #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_evt,
  input  logic [DW-1:0] i_thr,
  output logic          o_fire
);

  logic [DW-1:0] r_dc;
  logic [DW:0]   w_thr;
  logic [DW:0]   w_next;

  assign w_thr  = (i_thr == '0) ? {{DW{1'b0}}, 1'b1} : {1'b0, i_thr};
  assign w_next = {1'b0, r_dc} + {{DW{1'b0}}, 1'b1};
  // The live threshold is used, so lowering it below the run fires at once.
  assign o_fire = i_evt && (w_next >= w_thr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dc <= '0;
    end else if (!i_evt || o_fire) begin
      r_dc <= '0;
    end else if (r_dc != {DW{1'b1}}) begin
      r_dc <= w_next[DW-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/signo_hyst.sv
// ============================================================================
// Module : signo_hyst
// Brief  : Hysteretic, dwell-qualified sign extractor with registered +/-1
//          outputs, crossing pulses and a wrapping crossing counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module signo_hyst
  import signo_pkg::*;
#(
  parameter int R  = 14,
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [R-1:0]  in,
  input  logic [R-2:0]  hyst,
  input  logic [DW-1:0] dwell,
  input  logic          clr_cnt,
  output logic [R-1:0]  out,
  output logic [1:0]    out2bits,
  output logic          cross_p,
  output logic          cross_n,
  output logic [CW-1:0] cross_cnt
);

  state_t        r_state;
  logic          r_cross_p;
  logic          r_cross_n;
  logic [CW-1:0] r_cnt;

  state_t        w_state_nxt;
  logic          w_cross_p_nxt;
  logic          w_cross_n_nxt;
  logic [CW-1:0] w_cnt_nxt;

  logic signed [R:0] w_in_x;
  logic signed [R:0] w_hyst_x;
  logic              w_qual;
  logic              w_fire;
  logic [WORD_MAX-1:0] w_word;

  // One extra bit keeps -hyst and full-scale inputs free of overflow.
  assign w_in_x   = {in[R-1], in};
  assign w_hyst_x = {2'b00, hyst};
  assign w_qual   = (r_state == ST_POS) ? (w_in_x < -w_hyst_x) : (w_in_x > w_hyst_x);

  signo_dwell_cnt #(
    .DW (DW)
  ) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .i_evt  (w_qual),
    .i_thr  (dwell),
    .o_fire (w_fire)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_cross_p_nxt = 1'b0;
    w_cross_n_nxt = 1'b0;
    w_cnt_nxt     = r_cnt;
    if (w_fire) begin
      w_state_nxt   = (r_state == ST_POS) ? ST_NEG : ST_POS;
      w_cross_p_nxt = (r_state == ST_NEG);
      w_cross_n_nxt = (r_state == ST_POS);
      w_cnt_nxt     = r_cnt + {{(CW-1){1'b0}}, 1'b1};
    end
    if (clr_cnt) begin
      w_cnt_nxt = w_fire ? {{(CW-1){1'b0}}, 1'b1} : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_POS;
      r_cross_p <= 1'b0;
      r_cross_n <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cross_p <= w_cross_p_nxt;
      r_cross_n <= w_cross_n_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign w_word    = sgn_word(R, r_state);
  assign out       = w_word[R-1:0];
  assign out2bits  = sgn_2b(r_state);
  assign cross_p   = r_cross_p;
  assign cross_n   = r_cross_n;
  assign cross_cnt = r_cnt;

endmodule

`default_nettype wire

// File: doc/signo_hyst.md
Name: signo_hyst

Overview:
Sign extractor with hysteresis and dwell (debounce) qualification, registered outputs, and a zero-crossing event counter. It is the sequential successor of the combinational sign block. It converts a noisy signed R-bit error/demodulated signal into a clean ±1 square wave for the lock-in and dummy-simulator paths. It also reports transitions as single-cycle pulses and a running count.

Parameters:
R, 14, width of signed input and of the out bus
DW, 8, width of dwell threshold and dwell counter
CW, 16, width of the crossing counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
in  input  R  signed sample, one per clk
hyst  input  R-1  unsigned hysteresis half-width; must be quasi-static
dwell  input  DW  required consecutive qualifying samples before a flip; 0 is treated as 1
clr_cnt  input  1  synchronous clear of cross_cnt
out  output  R  signed +1 or -1, full width
out2bits  output  2  signed +1 (2'b01) or -1 (2'b11)
cross_p  output  1  one-cycle pulse on a NEG->POS flip
cross_n  output  1  one-cycle pulse on a POS->NEG flip
cross_cnt  output  CW  total flips since reset or clear; wraps modulo 2^CW

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state POS, out = {R-1{0},1}, out2bits = 01
  - cross_p = cross_n = 0, cross_cnt = 0, dwell counter dc = 0
- States: POS and NEG (1-bit state register). out and out2bits are decoded from the state register only, so there is no combinational path from in to out.
- Qualifying condition, compared in R+1-bit signed arithmetic with hyst zero-extended:
  - In POS: in < -hyst (strict).
  - In NEG: in > +hyst (strict).
  - in equal to ±hyst does not qualify.
  - hyst = 0: in = 0 never flips, and the state holds.
- Dwell counter dc:
  - On a clk edge with the condition true: if dc+1 >= max(dwell,1), flip state and set dc = 0. Otherwise increment dc, saturating at 2^DW-1.
  - On a clk edge with the condition false: dc = 0. Samples must be consecutive.
- Latency: with dwell <= 1, a qualifying sample present at edge k changes out after edge k (visible in cycle k+1). With dwell = D, out changes after the edge of the D-th consecutive qualifying sample.
- Pulses: cross_p / cross_n are registered and asserted in the same cycle the new state is visible, for exactly one cycle. They are never both high.
- Minimum spacing between flips is max(dwell,1) cycles.
- cross_cnt increments by 1 on each flip and wraps from 2^CW-1 to 0.
  - clr_cnt alone sets it to 0.
  - clr_cnt together with a flip on the same edge sets it to 1.
- dwell changed mid-count: the comparison uses the current value, so lowering dwell below dc flips on the next qualifying sample.
- rst mid-count or mid-dwell: everything returns to reset values on that edge. A pending qualification is discarded.
- Full-scale inputs: in = -2^(R-1) with hyst = 2^(R-1)-1 qualifies in POS. in = 2^(R-1)-1 never qualifies at that hyst. No overflow is possible thanks to the R+1-bit compare.

Decomposition:
- Package signo_pkg:
  - state encoding ST_POS = 1'b0, ST_NEG = 1'b1
  - functions sgn_word(R, state) and sgn_2b(state) returning the ±1 constants
  - localparam DW_MAX
- One natural sub-module: signo_dwell_cnt, a saturating consecutive-event counter with threshold compare, which emits a "fire" strobe and self-clears.
- Hysteresis compare, state register and crossing counter stay in the top level.

Test Plan:
- Reset and hold: assert rst, then in = -100, hyst = 0, dwell = 1 -> out = +1 during rst; after release, out = 0x3FFF (-1) one cycle later, out2bits = 11, cross_n pulse, cross_cnt = 1.
- Hysteresis band: hyst = 50, dwell = 1, in sweeps -50..+50 from POS -> no flip. in = -51 -> flip to NEG. in = +50 -> holds NEG. in = +51 -> flip to POS with cross_p, cross_cnt = 2.
- Dwell debounce: dwell = 4, in = -200 for 3 cycles, +10 for 1 cycle, then -200 for 4 cycles -> no flip on the first burst; flip after the 4th sample of the second burst.
- Counter wrap and clear: CW = 4, toggle in to force 16 flips -> cross_cnt returns to 0. Then clr_cnt with a simultaneous flip -> cross_cnt = 1.
- Mid-operation events: dwell = 8 with dc = 5, drop dwell to 3 -> flip on the next qualifying sample. rst asserted with dc = 6 -> state POS, dc = 0, no pulse.
- Full-scale: R = 14, hyst = 8191, in = -8192 -> flip to NEG. in = 8191 -> no flip back.
